// File: rtl/reg_op_pkg.sv
//============================================================================
// Module : reg_op_pkg
// Desc   : Opcode constants (register funsel encoding) and FSM state type
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

package reg_op_pkg;

  localparam logic [1:0] CLR = 2'b00;
  localparam logic [1:0] LD  = 2'b01;
  localparam logic [1:0] DEC = 2'b10;
  localparam logic [1:0] INC = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // inc/dec are the only repeat-counted opcodes
  function automatic logic is_repeat_op(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_op_scheduler_rr_arbiter.sv
//============================================================================
// Module : rr_arbiter
// Desc   : Rotating-priority arbiter; search starts at 'pointer' and wraps
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NReq = 4,
  parameter int PtrW = (NReq > 1) ? $clog2(NReq) : 1
) (
  input  logic [NReq-1:0] req,
  input  logic [PtrW-1:0] pointer,
  output logic [NReq-1:0] grant
);

  logic [NReq-1:0] w_mask;
  logic [NReq-1:0] w_hi;

  // Requests at or above the pointer win first; otherwise wrap to the lowest.
  assign w_mask = ~((NReq'(1) << pointer) - NReq'(1));
  assign w_hi   = req & w_mask;

  always_comb begin
    grant = '0;
    if (|w_hi) grant = w_hi & (~w_hi + NReq'(1));
    else       grant = req & (~req + NReq'(1));
  end

endmodule

`default_nettype wire

// File: rtl/reg_op_scheduler.sv
//============================================================================
// Module : reg_op_scheduler
// Desc   : Round-robin scheduler issuing clear/load/inc/dec operations to a
//          bank of registers. Optional abort input: REG_OP_SCHED_ABORT_EN.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module reg_op_scheduler
  import reg_op_pkg::*;
#(
  parameter int NBits = 16,
  parameter int NReq  = 4,
  parameter int NRegs = 4,
  parameter int CntW  = 4
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic [NReq-1:0]                                req,
  input  logic [2*NReq-1:0]                              req_op,
  input  logic [NReq*((NRegs > 1) ? $clog2(NRegs) : 1)-1:0] req_sel,
  input  logic [NReq*NBits-1:0]                          req_data,
  input  logic [NReq*CntW-1:0]                           req_cnt,
`ifdef REG_OP_SCHED_ABORT_EN
  input  logic                                           abort,
`endif
  output logic [NReq-1:0]                                gnt,
  output logic [NReq-1:0]                                done,
  output logic                                           busy,
  output logic [1:0]                                     rf_funsel,
  output logic [NRegs-1:0]                               rf_e,
  output logic [NBits-1:0]                               rf_i
);

  localparam int SelW = (NRegs > 1) ? $clog2(NRegs) : 1;
  localparam int PtrW = (NReq > 1) ? $clog2(NReq) : 1;

  state_t            r_state, w_next_state;
  logic [PtrW-1:0]   r_ptr, w_win_idx, w_next_ptr;
  logic [CntW-1:0]   r_cnt, w_cnt;
  logic [1:0]        r_op, w_op;
  logic [SelW-1:0]   r_sel, w_sel;
  logic [NBits-1:0]  r_data, w_data;
  logic [NReq-1:0]   r_owner, w_grant;
  logic              w_take, w_abort, w_repeat, w_active;

`ifdef REG_OP_SCHED_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  rr_arbiter #(
    .NReq (NReq),
    .PtrW (PtrW)
  ) u_arb (
    .req     (req),
    .pointer (r_ptr),
    .grant   (w_grant)
  );

  // Pull the winner's operands out of the flattened request buses.
  always_comb begin
    w_win_idx = '0;
    w_op      = '0;
    w_sel     = '0;
    w_data    = '0;
    w_cnt     = '0;
    for (int i = 0; i < NReq; i++) begin
      if (w_grant[i]) begin
        w_win_idx = PtrW'(i);
        w_op      = req_op[2*i +: 2];
        w_sel     = req_sel[SelW*i +: SelW];
        w_data    = req_data[NBits*i +: NBits];
        w_cnt     = req_cnt[CntW*i +: CntW];
      end
    end
  end

  assign w_next_ptr = (w_win_idx == PtrW'(NReq-1)) ? '0 : w_win_idx + 1'b1;
  assign w_take     = (r_state == IDLE) && (|req);
  assign w_repeat   = is_repeat_op(r_op);
  assign w_active   = !w_repeat || (r_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_op    <= CLR;
      r_sel   <= '0;
      r_data  <= '0;
      r_owner <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_take) begin
        r_ptr   <= w_next_ptr;
        r_cnt   <= w_cnt;
        r_op    <= w_op;
        r_sel   <= w_sel;
        r_data  <= w_data;
        r_owner <= w_grant;
      end else if (r_state == EXEC && w_repeat && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (|req) w_next_state = EXEC;
      // r_cnt holds the pulses still owed, so the last one is issued at 1
      EXEC: if (w_abort || !w_repeat || r_cnt <= CntW'(1)) w_next_state = DONE;
      DONE: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Out-of-range selects match no bit, so the op completes without an enable.
  always_comb begin
    rf_e = '0;
    if (r_state == EXEC && w_active && !w_abort) begin
      for (int i = 0; i < NRegs; i++) begin
        if (r_sel == SelW'(i)) rf_e[i] = 1'b1;
      end
    end
  end

  // rst_n gating keeps gnt low while reset is held with requests pending.
  assign gnt       = (r_state == IDLE && rst_n) ? w_grant : '0;
  assign done      = (r_state == DONE) ? r_owner : '0;
  assign busy      = (r_state != IDLE);
  assign rf_funsel = r_op;
  assign rf_i      = r_data;

endmodule

`default_nettype wire

// File: tb/tb_reg_op_scheduler.sv
//============================================================================
// Module : tb_reg_op_scheduler
// Desc   : Directed self-checking bench for reg_op_scheduler
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module tb_reg_op_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [7:0]  req_op;
  logic [7:0]  req_sel;
  logic [63:0] req_data;
  logic [15:0] req_cnt;
`ifdef REG_OP_SCHED_ABORT_EN
  logic        abort;
`endif
  logic [3:0]  gnt, done, rf_e;
  logic        busy;
  logic [1:0]  rf_funsel;
  logic [15:0] rf_i;

  int checks   = 0;
  int failures = 0;

  reg_op_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_op    (req_op),
    .req_sel   (req_sel),
    .req_data  (req_data),
    .req_cnt   (req_cnt),
`ifdef REG_OP_SCHED_ABORT_EN
    .abort     (abort),
`endif
    .gnt       (gnt),
    .done      (done),
    .busy      (busy),
    .rf_funsel (rf_funsel),
    .rf_e      (rf_e),
    .rf_i      (rf_i)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [1:0] sel,
                         input logic [15:0] d, input logic [3:0] c);
    req_op[i*2 +: 2]    = op;
    req_sel[i*2 +: 2]   = sel;
    req_data[i*16 +: 16] = d;
    req_cnt[i*4 +: 4]   = c;
    req[i]              = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req = '0; req_op = '0; req_sel = '0; req_data = '0; req_cnt = '0;
    step; step;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (gnt !== 4'b0) begin failures++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    checks++; if (done !== 4'b0) begin failures++; $display("FAIL reset_done: got %b expected 0000", done); end
    checks++; if (rf_e !== 4'b0) begin failures++; $display("FAIL reset_rf_e: got %b expected 0000", rf_e); end
    checks++; if (rf_funsel !== 2'b00) begin failures++; $display("FAIL reset_funsel: got %b expected 00", rf_funsel); end
    checks++; if (rf_i !== 16'h0) begin failures++; $display("FAIL reset_rf_i: got %h expected 0000", rf_i); end
    rst_n = 1'b1;
    step;
  endtask

  task automatic test_load;
    set_req(1, 2'b01, 2'd2, 16'h00A5, 4'd0);
    #1;
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL load_gnt: got %b expected 0010", gnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL load_idle_busy: got %b expected 0", busy); end
    step;
    req = '0;
    checks++; if (rf_e !== 4'b0100) begin failures++; $display("FAIL load_rf_e: got %b expected 0100", rf_e); end
    checks++; if (rf_funsel !== 2'b01) begin failures++; $display("FAIL load_funsel: got %b expected 01", rf_funsel); end
    checks++; if (rf_i !== 16'h00A5) begin failures++; $display("FAIL load_rf_i: got %h expected 00a5", rf_i); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL load_busy: got %b expected 1", busy); end
    step;
    checks++; if (done !== 4'b0010) begin failures++; $display("FAIL load_done: got %b expected 0010", done); end
    checks++; if (rf_e !== 4'b0) begin failures++; $display("FAIL load_rf_e_after: got %b expected 0000", rf_e); end
    step;
    checks++; if (done !== 4'b0 || busy !== 1'b0) begin failures++; $display("FAIL load_idle: got done=%b busy=%b expected 0000/0", done, busy); end
  endtask

  task automatic test_inc;
    int pulses = 0;
    int done_at = 0;
    set_req(0, 2'b11, 2'd0, 16'h0, 4'd5);
    #1;
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL inc_gnt: got %b expected 0001", gnt); end
    step;
    req = '0;
    for (int c = 1; c <= 20; c++) begin
      if (done !== 4'b0) begin done_at = c; break; end
      if (rf_e === 4'b0001) begin
        pulses++;
        checks++; if (rf_funsel !== 2'b11) begin failures++; $display("FAIL inc_funsel: got %b expected 11", rf_funsel); end
      end
      step;
    end
    checks++; if (pulses != 5) begin failures++; $display("FAIL inc_pulses: got %0d expected 5", pulses); end
    checks++; if (done_at != 6) begin failures++; $display("FAIL inc_latency: got %0d expected 6", done_at); end
    checks++; if (done !== 4'b0001) begin failures++; $display("FAIL inc_done: got %b expected 0001", done); end
    step;
  endtask

  task automatic test_dec_zero;
    set_req(3, 2'b10, 2'd1, 16'h0, 4'd0);
    #1;
    checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL dec0_gnt: got %b expected 1000", gnt); end
    step;
    req = '0;
    checks++; if (rf_e !== 4'b0 || busy !== 1'b1) begin failures++; $display("FAIL dec0_exec: got rf_e=%b busy=%b expected 0000/1", rf_e, busy); end
    step;
    checks++; if (done !== 4'b1000 || rf_e !== 4'b0) begin failures++; $display("FAIL dec0_done: got done=%b rf_e=%b expected 1000/0000", done, rf_e); end
    step;
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_g;
    req_op = '0; req_sel = '0; req_cnt = '0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      #1;
      checks++; if (gnt !== exp_g) begin failures++; $display("FAIL rr_gnt%0d: got %b expected %b", k, gnt, exp_g); end
      step;
      if (k == 4) req = '0;
      checks++; if (gnt !== 4'b0) begin failures++; $display("FAIL rr_busy_gnt%0d: got %b expected 0000", k, gnt); end
      step;
      checks++; if (done !== exp_g) begin failures++; $display("FAIL rr_done%0d: got %b expected %b", k, done, exp_g); end
      step;
    end
  endtask

  task automatic test_back_to_back;
    set_req(2, 2'b00, 2'd0, 16'h0, 4'd0);
    #1;
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL drop_gnt: got %b expected 0100", gnt); end
    step;
    req = 4'b0001;
    step;
    req = '0;
    step;
    #1;
    checks++; if (gnt !== 4'b0 || busy !== 1'b0) begin failures++; $display("FAIL drop_ignored: got gnt=%b busy=%b expected 0000/0", gnt, busy); end
    step;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drop_stays_idle: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid;
    set_req(2, 2'b11, 2'd3, 16'h0, 4'd8);
    #1;
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL rmid_gnt: got %b expected 0100", gnt); end
    step;
    req = '0;
    checks++; if (rf_e !== 4'b1000) begin failures++; $display("FAIL rmid_rf_e1: got %b expected 1000", rf_e); end
    step;
    step;
    checks++; if (rf_e !== 4'b1000 || busy !== 1'b1) begin failures++; $display("FAIL rmid_rf_e3: got rf_e=%b busy=%b expected 1000/1", rf_e, busy); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rf_e !== 4'b0 || busy !== 1'b0) begin failures++; $display("FAIL rmid_async: got rf_e=%b busy=%b expected 0000/0", rf_e, busy); end
    checks++; if (rf_funsel !== 2'b00 || rf_i !== 16'h0) begin failures++; $display("FAIL rmid_rf_out: got funsel=%b rf_i=%h expected 00/0000", rf_funsel, rf_i); end
    for (int c = 0; c < 2; c++) begin
      step;
      checks++; if (done !== 4'b0) begin failures++; $display("FAIL rmid_no_done_rst: got %b expected 0000", done); end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step;
      checks++; if (done !== 4'b0 || busy !== 1'b0) begin failures++; $display("FAIL rmid_no_done: got done=%b busy=%b expected 0000/0", done, busy); end
    end
    req_op = '0; req_cnt = '0; req_sel = '0;
    req = 4'b1111;
    #1;
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL rmid_ptr: got %b expected 0001", gnt); end
    step;
    req = '0;
    step;
    step;
  endtask

`ifdef REG_OP_SCHED_ABORT_EN
  task automatic test_abort;
    int pulses = 0;
    set_req(1, 2'b11, 2'd1, 16'h0, 4'd6);
    #1;
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL abort_gnt: got %b expected 0010", gnt); end
    step;
    req = '0;
    if (rf_e === 4'b0010) pulses++;
    step;
    abort = 1'b1;
    #1;
    if (rf_e !== 4'b0) pulses++;
    step;
    abort = 1'b0;
    checks++; if (pulses != 1) begin failures++; $display("FAIL abort_pulses: got %0d expected 1", pulses); end
    checks++; if (done !== 4'b0010) begin failures++; $display("FAIL abort_done: got %b expected 0010", done); end
    step;
  endtask
`endif

  initial begin
`ifdef REG_OP_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    test_reset;
    test_load;
    test_inc;
    test_dec_zero;
    test_round_robin;
    test_back_to_back;
    test_reset_mid;
`ifdef REG_OP_SCHED_ABORT_EN
    test_abort;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
